stream_serializer: RTL and testbench
====================================

# stream_serializer

Transmit-side width converter for the on-chip valid/ready stream fabric. It accepts one wide word of `BEATS` narrow beats per input handshake and emits it as a sequence of `DATA_WIDTH`-bit beats, least-significant beat first. It marks the final beat with `last_o`. It sits upstream of the narrow stream FIFOs and links and produces the beats that the receiving end buffers and reassembles.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: width of one output beat.
- `BEATS`, default 4: number of beats per input word; must be at least 2.
- `CNT_WIDTH`, default `$clog2(BEATS)`: width of the beat counter and of `len_i`.

**Ports** (clock and reset first)
- `ACLK` in 1: clock.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `data_i` in `DATA_WIDTH*BEATS`: wide input word.
- `valid_i` in 1: input word valid.
- `ready_o` out 1: serializer can accept a word.
- `len_i` in `CNT_WIDTH`: number of beats minus 1. Present only with `STREAM_SERIALIZER_LEN_EN`.
- `data_o` out `DATA_WIDTH`: current beat.
- `valid_o` out 1: beat valid.
- `last_o` out 1: current beat is the final beat of the word.
- `ready_i` in 1: downstream accepts the beat.

## Operation

- **Handshakes:** input accept = `valid_i && ready_o`; output transfer = `valid_o && ready_i`.
- **States:** IDLE and SEND.
  - IDLE → SEND on input accept.
  - SEND → IDLE on an output transfer with `last_o=1` and no simultaneous input accept.
  - SEND → SEND on an output transfer with `last_o=1` and a simultaneous input accept (back-to-back words).
- **Accept:** on input accept, load `data_i` into the shift register, set `beat_cnt=0`, and set `end_cnt`:
  - without the macro, `end_cnt = BEATS-1`;
  - with the macro, `end_cnt = min(len_i, BEATS-1)`.
- **Output beat:** `data_o` = shift register bits `[DATA_WIDTH-1:0]`.
- **Advance:** on each non-final output transfer, shift the register right by `DATA_WIDTH` and increment `beat_cnt`.
- **Output control:**
  - `valid_o = (state==SEND)`.
  - `last_o = valid_o && (beat_cnt==end_cnt)`.
  - `ready_o = (state==IDLE) || (valid_o && ready_i && last_o)`. This path is combinational from `ready_i`.
- **Stability:** while `valid_o=1` and `ready_i=0`, `data_o` and `last_o` hold stable. Beats are never dropped or reordered.
- **Counter range:** `beat_cnt` never exceeds `end_cnt`. There is no wrap-around beyond it.

## Timing

- **Reset values (async assert):**
  - state = IDLE, `valid_o=0`, `last_o=0`, `data_o=0`, `beat_cnt=0`.
  - `ready_o=1` from the first cycle after reset.
- **Latency:** a word accepted at edge N presents beat 0 after edge N (same cycle as N+1 sampling). With `ready_i` held high, beat k transfers at edge N+1+k.
- **Throughput:** 1 beat per cycle with `ready_i=1`. Back-to-back words have no bubble: the next word's beat 0 follows the previous `last_o` beat directly.
- **Reset mid-message:** the message is discarded, no `last_o` is emitted, and no partial beat is presented after deassertion.
- **Backpressure:** `ready_i` low for any number of cycles stalls the serializer with no state change.

## Configuration

- **Macro:** `STREAM_SERIALIZER_LEN_EN`.
- **Defined:**
  - the `len_i` port exists and short words of 1..BEATS beats are supported;
  - `len_i` values above `BEATS-1` saturate to `BEATS-1`;
  - `len_i=0` produces a single beat with `last_o=1`.
- **Undefined:** the `len_i` port is absent and every word is exactly `BEATS` beats.

## Structure

- **Package `stream_pkg`:**
  - enum `stream_ser_state_t` {IDLE, SEND};
  - a localparam helper for the minimum counter width, `max(1, $clog2(BEATS))`.
- **Sub-modules:** none. The shift register and counter stay inline. The integrator places a `stream_fifo` downstream when buffering is needed.

## Test plan

- **Reset:** reset, then idle. Expect `ready_o=1`, `valid_o=0`, `last_o=0`, `data_o=0`.
- **Single word, full speed:** `BEATS=4`, `data_i=128'h44444444_33333333_22222222_11111111`, `ready_i=1`. Expect beats `11111111`, `22222222`, `33333333`, `44444444` on 4 consecutive cycles, `last_o` only on the 4th beat, and `ready_o=1` on that same cycle.
- **Back-to-back words:** two words, `valid_i` high continuously. Expect 8 consecutive beats with no gap and `last_o` on beats 4 and 8.
- **Backpressure:** `ready_i=0` for 3 cycles during beat 2. Expect `data_o=22222222` held, `valid_o=1`, `ready_o=0`, and the sequence resumes unchanged.
- **With `STREAM_SERIALIZER_LEN_EN`:**
  - `len_i=1`: expect 2 beats, `last_o` on the 2nd.
  - `len_i=0`: expect 1 beat with `last_o=1`.
  - `BEATS=5`, `len_i=7`: expect 5 beats.
- **Reset during beat 3:** expect `valid_o=0` immediately, no `last_o`, `ready_o=1` after release, and a new word serializes correctly.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream fabric width converters.
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_ser_state_t;

    // Beat counters need at least one bit even when $clog2 collapses to zero.
    function automatic int min_cnt_width(input int beats);
        return ($clog2(beats) < 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: one BEATS-beat word in, LS beat first out.
// Define STREAM_SERIALIZER_LEN_EN to add len_i for short words of 1..BEATS beats.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4,
    parameter int CNT_WIDTH  = min_cnt_width(BEATS)
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [DATA_WIDTH*BEATS-1:0]   data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
`ifdef STREAM_SERIALIZER_LEN_EN
    input  logic [CNT_WIDTH-1:0]          len_i,
`endif
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    output logic                          last_o,
    input  logic                          ready_i
);

    localparam logic [CNT_WIDTH-1:0] MAX_END = CNT_WIDTH'(BEATS - 1);

    stream_ser_state_t              state_q, state_d;
    logic [DATA_WIDTH*BEATS-1:0]    shift_q, shift_d;
    logic [CNT_WIDTH-1:0]           beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]           end_cnt_q, end_cnt_d;
    logic                           valid_q, valid_d;
    logic                           last_q, last_d;

    logic                           in_acc;
    logic                           out_xfer;
    logic [CNT_WIDTH-1:0]           load_end;
    logic [CNT_WIDTH-1:0]           beat_nxt;

`ifdef STREAM_SERIALIZER_LEN_EN
    assign load_end = (len_i > MAX_END) ? MAX_END : len_i;
`else
    assign load_end = MAX_END;
`endif

    assign out_xfer = valid_q && ready_i;
    // Refilling in the same cycle as the last beat leaves is what removes the bubble.
    assign ready_o  = (state_q == IDLE) || (out_xfer && last_q);
    assign in_acc   = valid_i && ready_o;
    assign beat_nxt = beat_cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        beat_cnt_d = beat_cnt_q;
        end_cnt_d  = end_cnt_q;
        valid_d    = valid_q;
        last_d     = last_q;

        if (in_acc) begin
            state_d    = SEND;
            shift_d    = data_i;
            beat_cnt_d = '0;
            end_cnt_d  = load_end;
            valid_d    = 1'b1;
            last_d     = (load_end == '0);
        end else if (out_xfer) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                shift_d    = shift_q >> DATA_WIDTH;
                beat_cnt_d = beat_nxt;
                last_d     = (beat_nxt == end_cnt_q);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            beat_cnt_q <= '0;
            end_cnt_q  <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            beat_cnt_q <= beat_cnt_d;
            end_cnt_q  <= end_cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign data_o  = shift_q[DATA_WIDTH-1:0];
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer; len_i scenarios run when STREAM_SERIALIZER_LEN_EN is defined.
module tb_stream_serializer;

    localparam int DW = 32;
    localparam int NB = 4;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [DW*NB-1:0]  data_i = '0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [DW-1:0]     data_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i = 1'b0;

    int errors = 0;
    int checks = 0;

    localparam logic [DW*NB-1:0] W1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [DW*NB-1:0] W2 = 128'h88888888_77777777_66666666_55555555;

    logic [DW-1:0] w1_beats [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [DW-1:0] b2b_beats [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                     32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

`ifdef STREAM_SERIALIZER_LEN_EN
    logic [1:0]        len_i = 2'd3;
    logic [DW*5-1:0]   d5_data_i = '0;
    logic              d5_valid_i = 1'b0;
    logic              d5_ready_o;
    logic [2:0]        d5_len_i = 3'd0;
    logic [DW-1:0]     d5_data_o;
    logic              d5_valid_o;
    logic              d5_last_o;
    logic              d5_ready_i = 1'b0;
`endif

    always #5 ACLK = ~ACLK;

    stream_serializer #(.DATA_WIDTH(DW), .BEATS(NB)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
`ifdef STREAM_SERIALIZER_LEN_EN
        .len_i   (len_i),
`endif
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

`ifdef STREAM_SERIALIZER_LEN_EN
    stream_serializer #(.DATA_WIDTH(DW), .BEATS(5)) dut5 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .data_i  (d5_data_i),
        .valid_i (d5_valid_i),
        .ready_o (d5_ready_o),
        .len_i   (d5_len_i),
        .data_o  (d5_data_o),
        .valid_o (d5_valid_o),
        .last_o  (d5_last_o),
        .ready_i (d5_ready_i)
    );
`endif

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) tick();
        ARESETn = 1'b1;
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", last_o); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    endtask

    task automatic test_single_word();
        ready_i = 1'b1;
        data_i  = W1;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (data_o !== w1_beats[k]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", k, data_o, w1_beats[k]); end
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", k, valid_o); end
            checks++; if (last_o !== (k == 3)) begin errors++; $display("FAIL single_last[%0d]: got %b want %b", k, last_o, (k == 3)); end
            checks++; if (ready_o !== (k == 3)) begin errors++; $display("FAIL single_ready[%0d]: got %b want %b", k, ready_o, (k == 3)); end
            tick();
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        data_i  = W1;
        valid_i = 1'b1;
        tick();
        data_i = W2;
        for (int k = 0; k < 8; k++) begin
            checks++; if (data_o !== b2b_beats[k]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, data_o, b2b_beats[k]); end
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, valid_o); end
            checks++; if (last_o !== (k == 3 || k == 7)) begin errors++; $display("FAIL b2b_last[%0d]: got %b want %b", k, last_o, (k == 3 || k == 7)); end
            tick();
            if (k == 3) begin
                valid_i = 1'b0;
                data_i  = '0;
            end
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b1;
        data_i  = W1;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++; if (data_o !== 32'h22222222) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want 22222222", s, data_o); end
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", s, valid_o); end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", s, ready_o); end
            checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL bp_hold_last[%0d]: got %b want 0", s, last_o); end
        end
        ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            checks++; if (data_o !== w1_beats[k]) begin errors++; $display("FAIL bp_resume_data[%0d]: got %h want %h", k, data_o, w1_beats[k]); end
            checks++; if (last_o !== (k == 3)) begin errors++; $display("FAIL bp_resume_last[%0d]: got %b want %b", k, last_o, (k == 3)); end
            tick();
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_idle_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_reset_mid_message();
        ready_i = 1'b1;
        data_i  = W1;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        checks++; if (data_o !== 32'h33333333) begin errors++; $display("FAIL rst_mid_pre: got %h want 33333333", data_o); end
        #2;
        ARESETn = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL rst_mid_last: got %b want 0", last_o); end
        tick();
        ARESETn = 1'b1;
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_after_valid: got %b want 0", valid_o); end
        data_i  = W2;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (data_o !== b2b_beats[k+4]) begin errors++; $display("FAIL rst_mid_new_data[%0d]: got %h want %h", k, data_o, b2b_beats[k+4]); end
            checks++; if (last_o !== (k == 3)) begin errors++; $display("FAIL rst_mid_new_last[%0d]: got %b want %b", k, last_o, (k == 3)); end
            tick();
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_new_idle: got %b want 0", valid_o); end
    endtask

`ifdef STREAM_SERIALIZER_LEN_EN
    task automatic test_len();
        ready_i = 1'b1;
        // Two-beat word
        len_i   = 2'd1;
        data_i  = W1;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++; if (data_o !== 32'h11111111) begin errors++; $display("FAIL len1_b0: got %h want 11111111", data_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL len1_b0_last: got %b want 0", last_o); end
        tick();
        checks++; if (data_o !== 32'h22222222) begin errors++; $display("FAIL len1_b1: got %h want 22222222", data_o); end
        checks++; if (last_o !== 1'b1) begin errors++; $display("FAIL len1_b1_last: got %b want 1", last_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL len1_idle: got %b want 0", valid_o); end
        // Single-beat word
        len_i   = 2'd0;
        data_i  = W2;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++; if (data_o !== 32'h55555555) begin errors++; $display("FAIL len0_data: got %h want 55555555", data_o); end
        checks++; if (last_o !== 1'b1) begin errors++; $display("FAIL len0_last: got %b want 1", last_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL len0_ready: got %b want 1", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL len0_idle: got %b want 0", valid_o); end
        len_i = 2'd3;
        // Five-beat instance with an oversize length saturates to five beats
        d5_ready_i = 1'b1;
        d5_len_i   = 3'd7;
        d5_data_i  = 160'h55555555_44444444_33333333_22222222_11111111;
        d5_valid_i = 1'b1;
        tick();
        d5_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (d5_data_o !== {4{4'(k + 1)}} * 32'h0) begin end
            checks--;
            checks++; if (d5_data_o !== (32'h11111111 * (k + 1))) begin errors++; $display("FAIL len7_data[%0d]: got %h want %h", k, d5_data_o, 32'h11111111 * (k + 1)); end
            checks++; if (d5_last_o !== (k == 4)) begin errors++; $display("FAIL len7_last[%0d]: got %b want %b", k, d5_last_o, (k == 4)); end
            tick();
        end
        checks++; if (d5_valid_o !== 1'b0) begin errors++; $display("FAIL len7_idle: got %b want 0", d5_valid_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
`ifdef STREAM_SERIALIZER_LEN_EN
        test_len();
`endif
        test_reset_mid_message();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
